// File: rtl/wb_stage_pl_if.sv
// MEM/WB bundle for the writeback stage: MEM-side inputs, pipeline controls
// and the register-file write port that the stage drives.
interface wb_stage_pl_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            flush;
  logic            mem_valid;
  logic            mem_reg_write;
  logic [4:0]      mem_rd;
  logic [1:0]      mem_result_src;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_read_data;
  logic [2:0]      mem_funct3;
  logic [XLEN-1:0] mem_pc_plus4;

  logic            we;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd;
  logic            wb_valid;

  // Upstream pipeline (MEM stage and hazard unit) side.
  modport master (
    output stall, flush, mem_valid, mem_reg_write, mem_rd, mem_result_src,
           mem_alu_result, mem_read_data, mem_funct3, mem_pc_plus4,
    input  we, a3, wd, wb_valid
  );

  // Writeback stage side.
  modport slave (
    input  stall, flush, mem_valid, mem_reg_write, mem_rd, mem_result_src,
           mem_alu_result, mem_read_data, mem_funct3, mem_pc_plus4,
    output we, a3, wd, wb_valid
  );
endinterface

// File: rtl/wb_stage_pl.sv
// Pipelined writeback stage: MEM/WB register, result select, load extension and
// register-file write port. Optional retire counter enabled by WB_RETIRE_CNT_EN.
module wb_stage_pl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_stage_pl_if.slave     mem_wb,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [1:0] {
    SRC_ALU   = 2'b00,
    SRC_LOAD  = 2'b01,
    SRC_PC4   = 2'b10,
    SRC_ALU_B = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } load_kind_e;

  logic [1:0]      w_off;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_result;
  logic            w_we_next;

  logic            r_wb_valid;
  logic            r_we;
  logic [4:0]      r_a3;
  logic [XLEN-1:0] r_wd;

  assign w_off = mem_wb.mem_alu_result[1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_byte      = 8'h00;
    w_half      = 16'h0000;
    w_load_data = mem_wb.mem_read_data;

    unique case (w_off)
      2'd0: w_byte = mem_wb.mem_read_data[7:0];
      2'd1: w_byte = mem_wb.mem_read_data[15:8];
      2'd2: w_byte = mem_wb.mem_read_data[23:16];
      2'd3: w_byte = mem_wb.mem_read_data[31:24];
      default: w_byte = 8'h00;
    endcase

    // Halfword position is chosen by off[1] alone; a misaligned off[0] is ignored.
    w_half = w_off[1] ? mem_wb.mem_read_data[31:16] : mem_wb.mem_read_data[15:0];

    case (load_kind_e'(mem_wb.mem_funct3))
      LD_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
      LD_H:    w_load_data = {{16{w_half[15]}}, w_half};
      LD_BU:   w_load_data = {24'h000000, w_byte};
      LD_HU:   w_load_data = {16'h0000, w_half};
      default: w_load_data = mem_wb.mem_read_data;
    endcase
  end

  always_comb begin
    w_result = mem_wb.mem_alu_result;
    case (result_src_e'(mem_wb.mem_result_src))
      SRC_LOAD: w_result = w_load_data;
      SRC_PC4:  w_result = mem_wb.mem_pc_plus4;
      default:  w_result = mem_wb.mem_alu_result;
    endcase
  end

  // x0 is hardwired to zero, so a write to it is suppressed here rather than in the file.
  assign w_we_next = mem_wb.mem_valid & mem_wb.mem_reg_write & (mem_wb.mem_rd != 5'd0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_we       <= 1'b0;
      r_a3       <= 5'd0;
      r_wd       <= '0;
    end else if (mem_wb.flush) begin
      r_wb_valid <= 1'b0;
      r_we       <= 1'b0;
    end else if (!mem_wb.stall) begin
      r_wb_valid <= mem_wb.mem_valid;
      r_we       <= w_we_next;
      r_a3       <= mem_wb.mem_rd;
      r_wd       <= w_result;
    end
  end

  // Write port comes straight from flops so it is settled before the negedge commit.
  assign mem_wb.we       = r_we;
  assign mem_wb.a3       = r_a3;
  assign mem_wb.wd       = r_wd;
  assign mem_wb.wb_valid = r_wb_valid;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retire_count;

  // An instruction retires on the edge where it leaves WB, so each counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_count <= '0;
    end else if (r_wb_valid && !mem_wb.stall && !mem_wb.flush) begin
      r_retire_count <= r_retire_count + CNT_W'(1);
    end
  end

  assign retire_count = r_retire_count;
`else
  assign retire_count = '0;
`endif

endmodule
